// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for alu_exec_unit: operation codes, FSM states and the
// default datapath width.
package alu_exec_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_MUL     = 4'b1000;
  localparam logic [3:0] OP_INVALID = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle for alu_exec_unit. The master drives
// requests and result back-pressure; the slave (the execution unit) answers.
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             inValid;
  logic             inReady;
  logic [3:0]       aluCtrl;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [4:0]       rdIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [4:0]       rdOut;

  modport master (
    output inValid, aluCtrl, opA, opB, rdIn, outReady,
    input  inReady, outValid, result, zero, overflow, illegal, rdOut
  );

  modport slave (
    input  inValid, aluCtrl, opA, opB, rdIn, outReady,
    output inReady, outValid, result, zero, overflow, illegal, rdOut
  );

endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier (low WIDTH bits of the unsigned product).
// A start pulse loads the operands; done is high during the final iteration.
module alu_mul_iter #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign done    = busy && (cnt == CNT_W'(CYCLES - 1));
  assign product = acc;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every register here, datapath included, is reset so an aborted
    // multiply leaves no stale partial product behind.
    if (reset) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
    end else if (start) begin
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
      cnt          <= '0;
      busy         <= 1'b1;
    end else if (busy) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain the shifts into the add.
      if (multiplier[0]) acc <= acc + multiplicand;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      cnt          <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit with registered result and valid/ready
// handshakes. Optional iterative multiply is enabled by the macro ALU_MUL_EN.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input logic            clock,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  if (MUL_CYCLES < 1) begin : g_bad_cfg
    $error("alu_exec_unit: MUL_CYCLES must be at least 1");
  end

  logic             accept;
  logic             alu_load;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             alu_illegal;

  assign accept = bus.inValid && bus.inReady;
  assign sum    = bus.opA + bus.opB;
  assign diff   = bus.opA - bus.opB;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_illegal  = 1'b0;
    case (bus.aluCtrl)
      OP_ADD: begin
        alu_result   = sum;
        alu_overflow = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result   = diff;
        alu_overflow = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) &&
                       (diff[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      OP_AND:     alu_result  = bus.opA & bus.opB;
      OP_OR:      alu_result  = bus.opA | bus.opB;
      OP_SLT:     alu_result  = {{(WIDTH-1){1'b0}}, $signed(bus.opA) < $signed(bus.opB)};
      OP_INVALID: alu_illegal = 1'b1;
      default:    alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  state_e           state;
  state_e           state_next;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic             mul_load;
  logic [WIDTH-1:0] mul_product;
  logic [4:0]       mul_rd;

  assign is_mul      = (bus.aluCtrl == OP_MUL);
  assign alu_load    = accept && !is_mul;
  assign bus.inReady = (state == IDLE) && (!bus.outValid || bus.outReady);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul)                    state_next = MUL;
      MUL:     if (mul_done)                            state_next = DONE;
      DONE:    if (!bus.outValid || bus.outReady)       state_next = IDLE;
      default:                                          state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == IDLE) && accept && is_mul;
    mul_load  = (state == DONE) && (!bus.outValid || bus.outReady);
  end

  // The destination tag travels with the multiply while the operands iterate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          mul_rd <= '0;
    else if (mul_start) mul_rd <= bus.rdIn;
  end

  alu_mul_iter #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.opA),
    .b       (bus.opB),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign alu_load    = accept;
  assign bus.inReady = !bus.outValid || bus.outReady;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.outValid <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b1;
      bus.overflow <= 1'b0;
      bus.illegal  <= 1'b0;
      bus.rdOut    <= '0;
    end else if (alu_load) begin
      bus.outValid <= 1'b1;
      bus.result   <= alu_result;
      bus.zero     <= (alu_result == '0);
      bus.overflow <= alu_overflow;
      bus.illegal  <= alu_illegal;
      bus.rdOut    <= bus.rdIn;
`ifdef ALU_MUL_EN
    end else if (mul_load) begin
      bus.outValid <= 1'b1;
      bus.result   <= mul_product;
      bus.zero     <= (mul_product == '0);
      bus.overflow <= 1'b0;
      bus.illegal  <= 1'b0;
      bus.rdOut    <= mul_rd;
`endif
    end else if (bus.outReady) begin
      bus.outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized
// traffic compared against an arithmetic reference model. Honours ALU_MUL_EN.
module tb_alu_exec_unit;

  localparam int W          = 32;
  localparam int MUL_CYCLES = W;
  localparam int OV         = W + 9;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(
    .WIDTH      (W),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Observed output bundle: {outValid, result, zero, overflow, illegal, rdOut}
  logic [OV-1:0] obs;
  assign obs = {bus.outValid, bus.result, bus.zero, bus.overflow, bus.illegal, bus.rdOut};

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         ill;
  } ref_t;

  function automatic logic [OV-1:0] pack_exp(logic v, logic [W-1:0] r, logic o,
                                             logic il, logic [4:0] rd);
    return {v, r, (r == '0), o, il, rd};
  endfunction

  function automatic ref_t ref_alu(logic [3:0] code, logic [W-1:0] a, logic [W-1:0] b);
    ref_t           r;
    longint         sa;
    longint         sb;
    longint         full;
    longint         smax;
    longint         smin;
    logic [2*W-1:0] prod;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r    = '0;
    case (code)
      4'b0010: begin full = sa + sb; r.res = W'(full); r.ovf = (full > smax) || (full < smin); end
      4'b0110: begin full = sa - sb; r.res = W'(full); r.ovf = (full > smax) || (full < smin); end
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0111: r.res = (sa < sb) ? W'(1) : W'(0);
`ifdef ALU_MUL_EN
      4'b1000: begin prod = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r.res = prod[W-1:0]; end
`endif
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] pick_code();
    logic [3:0] undef_codes [10] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10,
                                     4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    case ($urandom_range(0, 5))
      0:       return 4'b0010;
      1:       return 4'b0110;
      2:       return 4'b0000;
      3:       return 4'b0001;
      4:       return 4'b0111;
      default: return undef_codes[$urandom_range(0, 9)];
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] specials [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                                   32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  task automatic issue(logic [3:0] code, logic [W-1:0] a, logic [W-1:0] b, logic [4:0] rd);
    bus.inValid = 1'b1;
    bus.aluCtrl = code;
    bus.opA     = a;
    bus.opB     = b;
    bus.rdIn    = rd;
  endtask

  task automatic test_reset();
    logic [OV-1:0] e;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    bus.aluCtrl  = 4'b0000;
    bus.opA      = '0;
    bus.opB      = '0;
    bus.rdIn     = '0;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    e = pack_exp(1'b0, '0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if (obs !== e) $display("FAIL reset_outputs: got %h expected %h", obs, e);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL reset_inready: got %b expected 1", bus.inReady);
    else n_pass++;
  endtask

  task automatic test_add_overflow();
    logic [OV-1:0] e;
    ref_t          r;
    @(negedge clock);
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL add_inready: got %b expected 1", bus.inReady);
    else n_pass++;
    @(negedge clock);
    bus.inValid = 1'b0;
    e = pack_exp(1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'd3);
    n_checks++;
    if (obs !== e) $display("FAIL add_ovf_literal: got %h expected %h", obs, e);
    else n_pass++;
    r = ref_alu(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    e = pack_exp(1'b1, r.res, r.ovf, r.ill, 5'd3);
    n_checks++;
    if (obs !== e) $display("FAIL add_ovf_model: got %h expected %h", obs, e);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (bus.outValid !== 1'b0) $display("FAIL add_outvalid_clear: got %b expected 0", bus.outValid);
    else n_pass++;
  endtask

  task automatic test_sub_slt();
    logic [OV-1:0] e;
    @(negedge clock);
    issue(4'b0110, 32'd5, 32'd5, 5'd7);
    @(negedge clock);
    e = pack_exp(1'b1, '0, 1'b0, 1'b0, 5'd7);
    n_checks++;
    if (obs !== e) $display("FAIL sub_zero: got %h expected %h", obs, e);
    else n_pass++;
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd8);
    @(negedge clock);
    bus.inValid = 1'b0;
    e = pack_exp(1'b1, 32'd1, 1'b0, 1'b0, 5'd8);
    n_checks++;
    if (obs !== e) $display("FAIL slt_neg: got %h expected %h", obs, e);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [OV-1:0] e;
    @(negedge clock);
    issue(4'b1111, W'($urandom), W'($urandom), 5'd11);
    @(negedge clock);
    e = pack_exp(1'b1, '0, 1'b0, 1'b1, 5'd11);
    n_checks++;
    if (obs !== e) $display("FAIL illegal_1111: got %h expected %h", obs, e);
    else n_pass++;
    issue(4'b0010, 32'd10, 32'd20, 5'd12);
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL illegal_next_inready: got %b expected 1", bus.inReady);
    else n_pass++;
    @(negedge clock);
    e = pack_exp(1'b1, 32'd30, 1'b0, 1'b0, 5'd12);
    n_checks++;
    if (obs !== e) $display("FAIL illegal_next_add: got %h expected %h", obs, e);
    else n_pass++;
`ifndef ALU_MUL_EN
    issue(4'b1000, 32'd6, 32'd7, 5'd13);
    @(negedge clock);
    e = pack_exp(1'b1, '0, 1'b0, 1'b1, 5'd13);
    n_checks++;
    if (obs !== e) $display("FAIL mul_code_illegal: got %h expected %h", obs, e);
    else n_pass++;
`endif
    bus.inValid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [OV-1:0] ea;
    logic [OV-1:0] eb;
    ref_t          r;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    @(negedge clock);
    bus.outReady = 1'b0;
    a = pick_operand();
    b = pick_operand();
    r = ref_alu(4'b0010, a, b);
    ea = pack_exp(1'b1, r.res, r.ovf, r.ill, 5'd20);
    issue(4'b0010, a, b, 5'd20);
    @(negedge clock);
    n_checks++;
    if (obs !== ea) $display("FAIL bp_first: got %h expected %h", obs, ea);
    else n_pass++;
    a = pick_operand();
    b = pick_operand();
    r = ref_alu(4'b0110, a, b);
    eb = pack_exp(1'b1, r.res, r.ovf, r.ill, 5'd21);
    issue(4'b0110, a, b, 5'd21);
    #1;
    n_checks++;
    if (bus.inReady !== 1'b0) $display("FAIL bp_inready_held: got %b expected 0", bus.inReady);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({obs, bus.inReady} !== {ea, 1'b0})
        $display("FAIL bp_hold_%0d: got %h/%b expected %h/0", i, obs, bus.inReady, ea);
      else n_pass++;
    end
    bus.outReady = 1'b1;
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL bp_release_inready: got %b expected 1", bus.inReady);
    else n_pass++;
    @(negedge clock);
    bus.inValid = 1'b0;
    n_checks++;
    if (obs !== eb) $display("FAIL bp_no_bubble: got %h expected %h", obs, eb);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back(int n);
    logic [OV-1:0] e_prev;
    logic [3:0]    c;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    rd;
    ref_t          r;
    e_prev       = '0;
    bus.outReady = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clock);
      if (i > 0) begin
        n_checks++;
        if (obs !== e_prev) $display("FAIL b2b_%0d: got %h expected %h", i - 1, obs, e_prev);
        else n_pass++;
      end
      if (i < n) begin
        c  = pick_code();
        a  = pick_operand();
        b  = pick_operand();
        rd = 5'($urandom);
        r  = ref_alu(c, a, b);
        e_prev = pack_exp(1'b1, r.res, r.ovf, r.ill, rd);
        issue(c, a, b, rd);
      end else begin
        bus.inValid = 1'b0;
      end
    end
    @(negedge clock);
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [OV-1:0] e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    ref_t          r;
    bus.outReady = 1'b1;
    @(negedge clock);
    issue(4'b1000, 32'h0000_FFFF, 32'h0001_0001, 5'd9);
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL mul_accept_inready: got %b expected 1", bus.inReady);
    else n_pass++;
    @(negedge clock);
    issue(4'b0010, 32'd1, 32'd2, 5'd1);
    for (int cyc = 2; cyc <= MUL_CYCLES + 1; cyc++) begin
      @(negedge clock);
      n_checks++;
      if ({bus.outValid, bus.inReady} !== 2'b00)
        $display("FAIL mul_busy_%0d: got valid/ready %b%b expected 00", cyc, bus.outValid, bus.inReady);
      else n_pass++;
    end
    @(negedge clock);
    bus.inValid = 1'b0;
    e = pack_exp(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd9);
    n_checks++;
    if (obs !== e) $display("FAIL mul_literal: got %h expected %h", obs, e);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      a = pick_operand();
      b = W'($urandom);
      r = ref_alu(4'b1000, a, b);
      e = pack_exp(1'b1, r.res, r.ovf, r.ill, 5'(k + 16));
      issue(4'b1000, a, b, 5'(k + 16));
      @(negedge clock);
      bus.inValid = 1'b0;
      repeat (MUL_CYCLES + 1) @(negedge clock);
      n_checks++;
      if (obs !== e) $display("FAIL mul_rand_%0d: got %h expected %h", k, obs, e);
      else n_pass++;
    end
    @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid_op();
    logic [OV-1:0] e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          saw_valid;
    ref_t          r;
    @(negedge clock);
`ifdef ALU_MUL_EN
    bus.outReady = 1'b1;
    issue(4'b1000, W'($urandom), W'($urandom), 5'd25);
    @(negedge clock);
    bus.inValid = 1'b0;
    repeat (5) @(negedge clock);
`else
    bus.outReady = 1'b0;
    issue(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd25);
    @(negedge clock);
    bus.inValid = 1'b0;
    n_checks++;
    if (bus.outValid !== 1'b1) $display("FAIL rst_pre_valid: got %b expected 1", bus.outValid);
    else n_pass++;
`endif
    #2 reset = 1'b1;
    #1;
    e = pack_exp(1'b0, '0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if ({obs, bus.inReady} !== {e, 1'b1})
      $display("FAIL rst_async: got %h/%b expected %h/1", obs, bus.inReady, e);
    else n_pass++;
    @(negedge clock);
    reset        = 1'b0;
    bus.outReady = 1'b1;
    a = pick_operand();
    b = pick_operand();
    r = ref_alu(4'b0010, a, b);
    e = pack_exp(1'b1, r.res, r.ovf, r.ill, 5'd26);
    issue(4'b0010, a, b, 5'd26);
    #1;
    n_checks++;
    if (bus.inReady !== 1'b1) $display("FAIL rst_after_inready: got %b expected 1", bus.inReady);
    else n_pass++;
    @(negedge clock);
    bus.inValid = 1'b0;
    n_checks++;
    if (obs !== e) $display("FAIL rst_after_add: got %h expected %h", obs, e);
    else n_pass++;
    saw_valid = 1'b0;
    repeat (MUL_CYCLES + 3) begin
      @(negedge clock);
      if (bus.outValid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) $display("FAIL rst_no_stale_result: got valid 1 expected 0");
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_illegal();
    test_backpressure();
    test_back_to_back(40);
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and result.
REQ-002 Parameter: MUL_CYCLES, default WIDTH, iterations of the shift-add multiplier; applies only when ALU_MUL_EN is defined.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inValid  input  1  operation request valid.
REQ-006 inReady  output  1  unit accepts a request this cycle.
REQ-007 aluCtrl  input  4  operation code from the ALU control decoder.
REQ-008 opA, opB  input  WIDTH each  operands.
REQ-009 rdIn  input  5  destination register tag, carried alongside the operation.
REQ-010 outValid  output  1  result register holds a valid result.
REQ-011 outReady  input  1  downstream accepts the result this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 overflow  output  1  signed overflow on add/sub.
REQ-015 illegal  output  1  aluCtrl was unsupported.
REQ-016 rdOut  output  5  tag of the result.

Function
REQ-017 Accept on a rising edge with inValid && inReady; inReady = (state==IDLE) && (!outValid || outReady).
REQ-018 Codes:
- 0010: add.
- 0110: subtract (opA-opB).
- 0000: AND.
- 0001: OR.
- 0111: signed set-less-than, result 1 or 0 zero-extended.
REQ-019 Code 1111 and every other undefined code: result=0, illegal=1, overflow=0, latency 1, with outValid still asserted.
REQ-020 Single-cycle ops: result, flags and rdOut are registered; outValid rises on the edge after acceptance (latency 1).
REQ-021 Result width: arithmetic wraps modulo 2^WIDTH.
REQ-022 overflow is set only for add/sub, when operand signs make the signed result unrepresentable, and is 0 otherwise.
REQ-023 zero is computed from the registered result for every op, including illegal.
REQ-024 Output hold: result, flags, rdOut and outValid remain stable while outValid && !outReady.
REQ-025 outValid clears on outReady unless a new request is accepted on the same edge, which supports back-to-back full throughput.
REQ-026 State machine:
- States are IDLE, MUL, DONE.
- IDLE→MUL on accepting code 1000 (ALU_MUL_EN only).
- MUL→DONE after MUL_CYCLES iterations.
- DONE→IDLE when the product is loaded into the output register, which requires !outValid || outReady.
REQ-027 inReady=0 in MUL and DONE; inValid is ignored there.
REQ-028 Multiply result is the low WIDTH bits of the unsigned product, with overflow=0 and illegal=0.

Reset
REQ-029 Asynchronous reset forces state=IDLE, outValid=0, result=0, zero=1, overflow=0, illegal=0, rdOut=0, and clears the multiplier registers.
REQ-030 Reset mid-multiply aborts the operation with no result produced; inReady is 1 on the first edge after reset deasserts.

Configuration
REQ-031 Macro ALU_MUL_EN:
- Defined: code 1000 is an iterative multiply per REQ-026..028.
- Undefined: no MUL/DONE logic exists, code 1000 is illegal per REQ-019, and inReady reduces to !outValid || outReady.

Structure
REQ-032 Shared package holds:
- aluCtrl code constants (ADD, SUB, AND, OR, SLT, MUL, INVALID).
- the state enumeration.
- the default WIDTH.
REQ-033 One sub-module, alu_mul_iter, holds the shift-add multiplier with start/done handshake; it is instantiated only under ALU_MUL_EN.

Verification
REQ-034 The bench shall cover the following scenarios:
- Add 0x7FFFFFFF+1 → result 0x80000000, overflow=1, zero=0, outValid one cycle after accept.
- Sub 5-5, aluCtrl 0110 → result 0, zero=1, overflow=0; SLT -1 vs 1 → result 1.
- aluCtrl 1111 → result 0, illegal=1, zero=1; next op accepted normally.
- Back-pressure: outReady=0 for 3 cycles → outputs stable and inReady=0; outReady=1 with a new inValid → new result next edge, no bubble.
- ALU_MUL_EN: 0x0000FFFF*0x00010001 → 0xFFFFFFFF after MUL_CYCLES+1 cycles; inReady=0 throughout.
- Reset asserted mid-multiply → all outputs at reset values immediately; the next add completes normally.
